mux_port_arbiter: RTL and testbench

Two-requester round-robin arbiter that owns the select line of a shared 2:1 mux bank in the pipeline CPU. Typical use: the single memory port shared between instruction fetch (requester 0) and the data-memory stage (requester 1). It grants one requester at a time, drives the mux select to match, and bounds how long one requester may hold the port while the other waits.

---
 rtl/mux_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mux_port_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_port_arbiter.sv
// Purpose : two-requester round-robin arbiter driving the select of a shared 2:1 mux bank.
// Latency : request-to-grant 1 cycle from IDLE; handover to the waiting requester with no idle bubble.
// Backpres: contended ownership is capped at HOLD_MAX cycles; an uncontended grant is held indefinitely.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (returns to IDLE, sel=0, prio=0)
//   req0     requester 0 (e.g. instruction fetch) wants the port, level
//   req1     requester 1 (e.g. data-memory stage) wants the port, level
//   done     shared resource finished the current transaction, 1-cycle pulse
//   gnt0     requester 0 owns the port (registered)
//   gnt1     requester 1 owns the port (registered)
//   sel      mux select: 0 routes requester 0, 1 routes requester 1 (registered)
//   prio     round-robin pointer: requester preferred at the next contended grant (registered)
module mux_port_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic prio
);

  // Counter wide enough to reach HOLD_MAX-1; HOLD_MAX is at least 2 so CW >= 1.
  localparam int            CW        = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] hold_cnt;

  // A grant is "issued" whenever a grant state is (re)entered this edge:
  // fresh grant from IDLE, handover to the other requester, or re-grant.
  logic issue;
  logic issue_id;

  // Per-grant view of the requests, oriented to the current owner.
  logic own_id;
  logic req_own;
  logic req_oth;
  logic hold_hit;
  logic release_now;

  // ------------------------------------------------------------------
  // Next-state / grant decision
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    issue_id    = 1'b0;
    own_id      = 1'b0;
    req_own     = 1'b0;
    req_oth     = 1'b0;
    hold_hit    = 1'b0;
    release_now = 1'b0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          issue    = 1'b1;
          // Contention resolves through the round-robin pointer.
          issue_id = (req0 & req1) ? prio : req1;
        end
      end

      GRANT0, GRANT1: begin
        own_id   = (state == GRANT1);
        req_own  = own_id ? req1 : req0;
        req_oth  = own_id ? req0 : req1;
        // hold_cnt saturates, so a late contender still preempts on the
        // first cycle it is seen once the owner has used up its budget.
        hold_hit = (hold_cnt == HOLD_LAST) & req_oth;

        release_now = done | ~req_own | hold_hit;

        if (release_now) begin
          if (req_oth) begin
            // Direct handover, no idle bubble.
            issue    = 1'b1;
            issue_id = ~own_id;
          end else if (req_own & done) begin
            // Owner finished one transaction and still wants the port.
            issue    = 1'b1;
            issue_id = own_id;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (issue) begin
      state_nxt = issue_id ? GRANT1 : GRANT0;
    end
  end

  // ------------------------------------------------------------------
  // State, hold counter, mux select and round-robin pointer
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      sel      <= 1'b0;
      prio     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        // sel moves only together with a grant; it is left alone in IDLE
        // so the mux output does not toggle without an owner.
        hold_cnt <= '0;
        sel      <= issue_id;
        prio     <= ~issue_id;
      end else if ((state != IDLE) && (hold_cnt != HOLD_LAST)) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
    end
  end

  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);

endmodule

// File: tb/tb_mux_port_arbiter.sv
// Purpose : self-checking bench for mux_port_arbiter (directed steps, then random traffic).
// Latency : each step drives inputs, waits one rising edge, then compares 1 time unit later.
// Backpres: n/a -- the bench drives requests/done freely and follows a reference model.
module tb_mux_port_arbiter;

  localparam int HOLD_MAX = 8;

  logic clk;
  logic reset_n;
  logic req0;
  logic req1;
  logic done;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic prio;

  int n_pass;
  int n_total;

  // Reference model: who owns the port, how many cycles it has owned it,
  // and the last values of the select and round-robin pointer.
  int m_owner;   // -1 none, 0 or 1
  int m_held;
  bit m_sel;
  bit m_prio;

  mux_port_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req0    (req0),
    .req1    (req1),
    .done    (done),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .prio    (prio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_sel   = 1'b0;
    m_prio  = 1'b0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w;
    m_held  = 0;
    m_sel   = (w == 1);
    m_prio  = (w == 0);
  endtask

  // One rising edge of the arbiter described from its rules.
  task automatic model_edge();
    bit r [2];
    int x;
    int o;
    r[0] = req0;
    r[1] = req1;
    if (m_owner < 0) begin
      if (r[0] && r[1]) model_grant(int'(m_prio));
      else if (r[0])    model_grant(0);
      else if (r[1])    model_grant(1);
    end else begin
      x = m_owner;
      o = 1 - x;
      m_held++;
      if (done || !r[x] || (m_held >= HOLD_MAX && r[o])) begin
        if (r[o])                model_grant(o);
        else if (r[x] && done)   model_grant(x);
        else                     m_owner = -1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".gnt0"}, gnt0, m_owner == 0);
    chk({tag, ".gnt1"}, gnt1, m_owner == 1);
    chk({tag, ".sel"},  sel,  m_sel);
    chk({tag, ".prio"}, prio, m_prio);
  endtask

  task automatic step(input logic r0, input logic r1, input logic d, input string tag);
    req0 = r0;
    req1 = r1;
    done = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_gnt0"}, gnt0, 1'b0);
    chk({tag, ".rst_gnt1"}, gnt1, 1'b0);
    chk({tag, ".rst_sel"},  sel,  1'b0);
    chk({tag, ".rst_prio"}, prio, 1'b0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int cnt;
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b1;
    req0    = 1'b0;
    req1    = 1'b0;
    done    = 1'b0;
    model_reset();
    #1;
    async_reset("init");

    // Reset in the middle of a GRANT1, then first arbitration after release.
    step(1'b0, 1'b1, 1'b0, "g1");
    chk("g1.sel_before_reset", sel, 1'b1);
    async_reset("midgrant");
    step(1'b1, 1'b0, 1'b0, "after_rst");
    chk("after_rst.gnt0", gnt0, 1'b1);

    // Single requester: grant, re-grant on done, release to IDLE.
    step(1'b0, 1'b0, 1'b0, "drop0");
    step(1'b0, 1'b1, 1'b0, "single1");
    chk("single1.gnt1", gnt1, 1'b1);
    chk("single1.sel",  sel,  1'b1);
    step(1'b0, 1'b1, 1'b1, "regrant1");
    chk("regrant1.gnt1", gnt1, 1'b1);
    chk("regrant1.prio", prio, 1'b0);
    step(1'b0, 1'b0, 1'b0, "idle1");
    chk("idle1.gnt1", gnt1, 1'b0);
    chk("idle1.sel",  sel,  1'b1);

    // Contention round robin from reset: 0,1,0,1.
    async_reset("rr");
    step(1'b1, 1'b1, 1'b0, "rr0");
    chk("rr0.gnt0", gnt0, 1'b1);
    step(1'b1, 1'b1, 1'b1, "rr1");
    chk("rr1.gnt1", gnt1, 1'b1);
    chk("rr1.sel",  sel,  1'b1);
    step(1'b1, 1'b1, 1'b1, "rr2");
    chk("rr2.gnt0", gnt0, 1'b1);
    step(1'b1, 1'b1, 1'b1, "rr3");
    chk("rr3.gnt1", gnt1, 1'b1);
    step(1'b0, 1'b0, 1'b0, "rr_idle");

    // Preemption: req1 appears at grant cycle 3, gnt0 lasts exactly HOLD_MAX.
    cnt = 0;
    step(1'b1, 1'b0, 1'b0, "pre");
    for (int k = 0; k < 30; k++) begin
      if (gnt0 !== 1'b1) break;
      cnt++;
      step(1'b1, (cnt >= 3), 1'b0, "pre");
    end
    chk("pre.len_is_8", (cnt == HOLD_MAX), 1'b1);
    chk("pre.gnt1", gnt1, 1'b1);
    chk("pre.sel",  sel,  1'b1);
    step(1'b0, 1'b0, 1'b0, "pre_idle");

    // Late contender after the hold counter has saturated.
    step(1'b1, 1'b0, 1'b0, "late");
    for (int k = 1; k < 20; k++) step(1'b1, 1'b0, 1'b0, "late");
    chk("late.still_gnt0", gnt0, 1'b1);
    step(1'b1, 1'b1, 1'b0, "late_sw");
    chk("late_sw.gnt0", gnt0, 1'b0);
    chk("late_sw.gnt1", gnt1, 1'b1);
    step(1'b0, 1'b0, 1'b0, "late_idle");

    // done together with req0 dropping, no other request.
    step(1'b1, 1'b0, 1'b0, "dd");
    step(1'b0, 1'b0, 1'b1, "dd_rel");
    chk("dd_rel.gnt0", gnt0, 1'b0);
    chk("dd_rel.sel",  sel,  1'b0);
    chk("dd_rel.prio", prio, 1'b1);

    // Random traffic with sticky requests and occasional async reset.
    for (int i = 0; i < 3000; i++) begin
      logic r0;
      logic r1;
      logic d;
      r0 = ($urandom_range(0, 9) < 7) ? req0 : ~req0;
      r1 = ($urandom_range(0, 9) < 7) ? req1 : ~req1;
      d  = ($urandom_range(0, 5) == 0);
      step(r0, r1, d, "rand");
      if ($urandom_range(0, 249) == 0) async_reset("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
